// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one request at a time, launches it to an
// external ALU, waits a fixed per-opcode latency and returns the result.
module alu_issue_ctrl #(
    parameter int LAT_ALU = 2,
    parameter int LAT_MUL = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic signed [31:0] req_a,
    input  logic signed [31:0] req_b,
    input  logic [5:0]         req_op,
    input  logic [3:0]         req_tag,
    output logic               alu_load,
    output logic signed [31:0] alu_a,
    output logic signed [31:0] alu_b,
    output logic [5:0]         alu_op,
    input  logic signed [31:0] alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic signed [31:0] rsp_data,
    output logic [3:0]         rsp_tag,
    output logic               rsp_err,
    output logic [15:0]        op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [5:0] OP_MUL  = 6'd5;
    localparam logic [5:0] OP_LAST = 6'd5;

    localparam logic [3:0] CNT_ALU = 4'(LAT_ALU - 1);
    localparam logic [3:0] CNT_MUL = 4'(LAT_MUL - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_load;
    logic       accept;
    logic       op_ok;
    logic       rsp_fire;
    logic       capture;

    assign op_ok     = (req_op <= OP_LAST);
    assign rsp_valid = (state == S_RESP);
    assign alu_load  = (state == S_LOAD);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign capture   = (state == S_WAIT) && (cnt == 4'd0);
    assign accept    = req_valid && req_ready;

    // A response slot frees up on the same edge it retires, so RESP can accept.
    always_comb begin
        req_ready = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                (state == S_IDLE): req_ready = 1'b1;
                (state == S_RESP): req_ready = rsp_ready;
                default:           req_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        cnt_load = CNT_ALU;
        unique case (1'b1)
            (alu_op == OP_MUL): cnt_load = CNT_MUL;
            default:            cnt_load = CNT_ALU;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = op_ok ? S_LOAD : S_RESP;
            end
            S_LOAD: state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt == 4'd0)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                if (accept)
                    state_nxt = op_ok ? S_LOAD : S_RESP;
                else if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                rsp_tag <= req_tag;
                if (op_ok) begin
                    alu_a  <= req_a;
                    alu_b  <= req_b;
                    alu_op <= req_op;
                end else begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end

            if (state == S_LOAD)
                cnt <= cnt_load;
            else if ((state == S_WAIT) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;

            if (capture) begin
                rsp_data <= alu_result;
                rsp_err  <= 1'b0;
            end

            if (rsp_fire && (op_count != 16'hFFFF))
                op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a latency-accurate ALU model.
// Vectors come from a table; pipelined and reset cases are hand-written.
module tb_alu_issue_ctrl;

    localparam int LA = 2;
    localparam int LM = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic signed [31:0] req_a;
    logic signed [31:0] req_b;
    logic [5:0]         req_op;
    logic [3:0]         req_tag;
    logic               alu_load;
    logic signed [31:0] alu_a;
    logic signed [31:0] alu_b;
    logic [5:0]         alu_op;
    logic signed [31:0] alu_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic signed [31:0] rsp_data;
    logic [3:0]         rsp_tag;
    logic               rsp_err;
    logic [15:0]        op_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.LAT_ALU(LA), .LAT_MUL(LM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .alu_load  (alu_load),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    // ALU model: result only becomes valid LAT cycles after the launch pulse.
    logic [4:0] pcnt = 5'd0;
    int         lat_cur;

    always @(posedge clk) begin
        if (alu_load)
            pcnt <= 5'd1;
        else if (pcnt != 5'd0 && pcnt != 5'd31)
            pcnt <= pcnt + 5'd1;
    end

    always_comb begin
        lat_cur    = (alu_op == 6'd5) ? LM : LA;
        alu_result = 32'hDEADBEEF;
        if (!alu_load && int'(pcnt) >= lat_cur) begin
            case (alu_op)
                6'd0: alu_result = alu_a + alu_b;
                6'd1: alu_result = alu_a - alu_b;
                6'd2: alu_result = alu_a & alu_b;
                6'd3: alu_result = alu_a | alu_b;
                6'd4: alu_result = {31'd0, (alu_a < alu_b)};
                6'd5: alu_result = alu_a * alu_b;
                default: alu_result = 32'hDEADBEEF;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          stall;
    } vec_t;

    vec_t vecs[10];

    // Called at a negedge with the block idle; returns at a negedge, idle.
    task automatic run_op(input vec_t v);
        int n;
        int loads;
        int load_at;
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
        rsp_ready = (v.stall == 0);
        #1;
        chk({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 32'h12345678;
        req_b     = 32'h9ABCDEF0;
        req_op    = 6'd1;
        n         = 1;
        loads     = 0;
        load_at   = -1;
        while (!rsp_valid && n < 40) begin
            if (alu_load) begin
                loads++;
                if (load_at < 0)
                    load_at = n;
            end
            @(negedge clk);
            n++;
        end
        chk({v.name, " latency"}, 32'(n), 32'(v.lat));
        chk({v.name, " alu_load pulses"}, 32'(loads), v.err ? 32'd0 : 32'd1);
        if (!v.err)
            chk({v.name, " alu_load cycle"}, 32'(load_at), 32'd1);
        chk({v.name, " rsp_data"}, rsp_data, v.data);
        chk({v.name, " rsp_tag"}, 32'(rsp_tag), 32'(v.tag));
        chk({v.name, " rsp_err"}, 32'(rsp_err), 32'(v.err));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk({v.name, " stall valid"}, 32'(rsp_valid), 32'd1);
            chk({v.name, " stall data"}, rsp_data, v.data);
            chk({v.name, " stall ready"}, 32'(req_ready), 32'd0);
            chk({v.name, " stall count"}, 32'(op_count), 32'(exp_cnt));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        exp_cnt++;
        @(negedge clk);
        chk({v.name, " op_count"}, 32'(op_count), 32'(exp_cnt));
        chk({v.name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        vecs[0] = '{"ADD", 6'd0, 32'd10, 32'd5, 4'd3, 32'd15, 1'b0, 4, 0};
        vecs[1] = '{"MUL", 6'd5, 32'd6, 32'd7, 4'd1, 32'd42, 1'b0, 5, 0};
        vecs[2] = '{"MULBIG", 6'd5, 32'h00010000, 32'h00010000, 4'd2,
                    32'd0, 1'b0, 5, 0};
        vecs[3] = '{"SUB", 6'd1, 32'd5, 32'd10, 4'd6, 32'hFFFFFFFB,
                    1'b0, 4, 3};
        vecs[4] = '{"SLTNEG", 6'd4, 32'hFFFFFFFF, 32'd1, 4'd7, 32'd1,
                    1'b0, 4, 0};
        vecs[5] = '{"SLTF", 6'd4, 32'd20, 32'd15, 4'd8, 32'd0, 1'b0, 4, 0};
        vecs[6] = '{"BADOP", 6'h3F, 32'd1, 32'd2, 4'd9, 32'd0, 1'b1, 1, 0};
        vecs[7] = '{"OP6", 6'd6, 32'd3, 32'd4, 4'd10, 32'd0, 1'b1, 1, 2};
        vecs[8] = '{"ADDWRAP", 6'd0, 32'h7FFFFFFF, 32'd1, 4'd11,
                    32'h80000000, 1'b0, 4, 0};
        vecs[9] = '{"SLTPOS", 6'd4, 32'd15, 32'd20, 4'd12, 32'd1,
                    1'b0, 4, 0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset alu_load", 32'(alu_load), 32'd0);
        chk("reset op_count", 32'(op_count), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_tag", 32'(rsp_tag), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset alu_a", alu_a, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i]);

        // Back-to-back AND then OR with valid held across the retire edge.
        req_valid = 1'b1;
        req_op    = 6'd2;
        req_a     = 32'hFF00FF00;
        req_b     = 32'h0F0F0F0F;
        req_tag   = 4'd4;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_op  = 6'd3;
        req_tag = 4'd5;
        chk("b2b load1", 32'(alu_load), 32'd1);
        chk("b2b ready busy", 32'(req_ready), 32'd0);
        wait_rsp(n);
        chk("b2b lat1", 32'(n), 32'd4);
        chk("b2b data1", rsp_data, 32'h0F000F00);
        chk("b2b tag1", 32'(rsp_tag), 32'd4);
        chk("b2b ready resp", 32'(req_ready), 32'd1);
        @(posedge clk);
        exp_cnt++;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b no bubble", 32'(alu_load), 32'd1);
        chk("b2b valid gap", 32'(rsp_valid), 32'd0);
        chk("b2b alu_op2", 32'(alu_op), 32'd3);
        chk("b2b count1", 32'(op_count), 32'(exp_cnt));
        wait_rsp(n);
        chk("b2b lat2", 32'(n), 32'd4);
        chk("b2b data2", rsp_data, 32'hFF0FFF0F);
        chk("b2b tag2", 32'(rsp_tag), 32'd5);
        @(posedge clk);
        exp_cnt++;
        @(negedge clk);
        chk("b2b count2", 32'(op_count), 32'(exp_cnt));
        chk("b2b idle", 32'(rsp_valid), 32'd0);

        // Reset lands while the SLT is waiting on the ALU.
        req_valid = 1'b1;
        req_op    = 6'd4;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'd1;
        req_tag   = 4'd13;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst ready low", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
        chk("rst op_count", 32'(op_count), 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid || alu_load)
                seen++;
            @(negedge clk);
        end
        chk("rst no response", 32'(seen), 32'd0);
        chk("rst count held", 32'(op_count), 32'd0);

        run_op(vecs[9]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_ALU, default 2: cycles from alu_load cycle end to alu_result valid, opcodes 0-4.
REQ-002 SHALL have parameter LAT_MUL, default 3: same for MUL (opcode 5); both parameters legal range 1-15.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  upstream request valid.
REQ-006 SHALL have port req_ready  out  1  block accepts request.
REQ-007 SHALL have ports req_a, req_b  in  32 signed each  operands.
REQ-008 SHALL have port req_op  in  6  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL; 6-63 invalid.
REQ-009 SHALL have port req_tag  in  4  opaque ID returned with response.
REQ-010 SHALL have port alu_load  out  1  one-cycle launch pulse to ALU.
REQ-011 SHALL have ports alu_a, alu_b  out  32 signed  registered operands to ALU.
REQ-012 SHALL have port alu_op  out  6  registered opcode to ALU.
REQ-013 SHALL have port alu_result  in  32 signed  ALU output.
REQ-014 SHALL have port rsp_valid  out  1  response valid.
REQ-015 SHALL have port rsp_ready  in  1  downstream accepts response.
REQ-016 SHALL have ports rsp_data  out  32 signed, rsp_tag  out  4, rsp_err  out  1 (invalid opcode).
REQ-017 SHALL have port op_count  out  16  completed-response counter.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, WAIT, RESP.
REQ-019 Handshake SHALL complete on any rising edge with valid&&ready high; valid-side signals hold until completion.
REQ-020 req_ready SHALL be 1 in IDLE, 1 in RESP only when rsp_ready=1, else 0; forced 0 while rst=1.
REQ-021 On accept of a valid opcode SHALL register req_a/b/op/tag into alu_a/b/op and tag register, go to LOAD.
REQ-022 On accept of an invalid opcode SHALL skip LOAD/WAIT, go to RESP with rsp_err=1, rsp_data=0, alu_load never asserted.
REQ-023 LOAD SHALL assert alu_load for exactly one cycle, load countdown with LAT_MUL-1 (MUL) or LAT_ALU-1 (others), go to WAIT.
REQ-024 WAIT SHALL decrement counter each cycle; when counter=0, capture alu_result into rsp_data, rsp_err=0, go to RESP.
REQ-025 Latency from accept edge c: valid op rsp_valid first high in cycle c+2+LAT (ADD: c+4, MUL: c+5); invalid op c+1.
REQ-026 alu_a/b/op SHALL remain stable from LOAD through the capture cycle; changes on req_* while busy ignored.
REQ-027 RESP SHALL hold rsp_valid, rsp_data, rsp_tag, rsp_err stable until rsp_ready=1.
REQ-028 RESP with rsp_ready=1 and req_valid=1 SHALL retire response and accept new request same edge (to LOAD, or to RESP for invalid op) -- no idle bubble.
REQ-029 RESP with rsp_ready=1 and req_valid=0 SHALL go to IDLE, rsp_valid=0 next cycle.
REQ-030 op_count SHALL increment on every response handshake (incl. rsp_err), saturating at 16'hFFFF.
REQ-031 rsp_data SHALL pass alu_result unmodified (all 32 bits, no re-sign-extension or overflow check).

Reset
REQ-032 rst=1 at a rising edge SHALL force state IDLE, alu_load=0, rsp_valid=0, rsp_err=0, alu_a/b=0, alu_op=0, rsp_data=0, rsp_tag=0, op_count=0, counter=0.
REQ-033 rst asserted in any state (incl. mid-WAIT) SHALL discard in-flight op; no response produced afterwards.
REQ-034 First accept SHALL be possible on first edge after rst deasserts.

Verification (bench ALU model returns result LAT cycles after alu_load)
REQ-035 ADD a=10, b=5, tag=3, rsp_ready=1 -> one alu_load pulse at c+1; rsp_valid at c+4, rsp_data=15, tag=3, err=0.
REQ-036 MUL a=6, b=7; then MUL 65536*65536 -> 42 at c+5; second rsp_data=0 (low 32 bits).
REQ-037 SUB 5-10 with rsp_ready low 3 cycles -> rsp_data=-5 held stable, req_ready=0, op_count increments once on release.
REQ-038 Two back-to-back ops (AND FF00FF00/0F0F0F0F, OR same) with req_valid held -> second accepted on RESP retire edge; results 0F000F00, FF0FFF0F.
REQ-039 Opcode 6'h3F, tag=9 -> no alu_load, rsp_valid at c+1, rsp_err=1, rsp_data=0, tag=9.
REQ-040 SLT 32'hFFFFFFFF vs 1 with rst pulsed in WAIT -> rsp_valid never asserts, op_count=0; fresh SLT 15,20 afterwards -> rsp_data=1.
